// File: rtl/game_pkg.sv
// Shared definitions for the game front end: direction encodings, the
// opposite-direction test and the width of the tick counter.
package game_pkg;

    localparam int TICK_CNT_W = 16;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    // The encodings are chosen so that opposite pairs differ in both bits.
    function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
        return (a ^ b) == 2'b11;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchronizer, stable-time debounce and a
// single-cycle press pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DB_CYCLES = 65536
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          synced;

    // The synchronizer carries the inverted (active-high) value so that its
    // reset state of 0 means "not pressed".
    assign synced = sync_q[1];

    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (synced != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = synced;
                press_d = synced;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], ~btn_n};
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/game_tick_input.sv
// Game timebase (tick, clear_pulse, tick_count) and direction capture from
// debounced push buttons.
module game_tick_input
    import game_pkg::*;
#(
    parameter int BASE_PERIOD = 4194304,
    parameter int CLEAR_LEAD  = 589824,
    parameter int N_BTN       = 4,
    parameter int DB_CYCLES   = 65536
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_BTN-1:0]      btn_n,
    input  logic [1:0]            speed,
    input  logic                  pause,
    output logic [N_BTN-1:0]      btn_level,
    output logic [N_BTN-1:0]      btn_press,
    output logic [1:0]            dir,
    output logic                  clear_pulse,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_count
);

    localparam int PW = $clog2(BASE_PERIOD + 1);

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .btn_n(btn_n[i]),
            .level(btn_level[i]),
            .press(btn_press[i])
        );
    end

    logic [PW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         period_q, period_d;
    logic [1:0]            dir_q, dir_d;
    logic [1:0]            pend_q, pend_d;
    logic [TICK_CNT_W-1:0] tc_q, tc_d;

    logic       at_end, at_clear;
    logic       tick_c, clear_c;
    logic       press_any;
    logic [1:0] press_dir;
    logic [1:0] ref_dir;

    assign at_end = (cnt_q == period_q - PW'(1));
    // A clear lead as long as the period has no slot to fire in.
    assign at_clear = (period_q > PW'(CLEAR_LEAD)) &&
                      (cnt_q == period_q - PW'(CLEAR_LEAD) - PW'(1));
    assign tick_c  = at_end   & ~pause & ~reset;
    assign clear_c = at_clear & ~pause & ~reset;

    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        if (!pause) begin
            if (at_end) begin
                cnt_d    = '0;
                period_d = PW'(BASE_PERIOD >> speed);
            end else begin
                cnt_d = cnt_q + PW'(1);
            end
        end
    end

    assign press_any = |btn_press[3:0];

    always_comb begin
        press_dir = DIR_LEFT;
        if (btn_press[0])      press_dir = DIR_RIGHT;
        else if (btn_press[1]) press_dir = DIR_DOWN;
        else if (btn_press[2]) press_dir = DIR_UP;
    end

    // In a tick cycle the pending value is what dir becomes, so presses are
    // judged against it rather than the outgoing dir.
    assign ref_dir = tick_c ? pend_q : dir_q;

    always_comb begin
        pend_d = pend_q;
        dir_d  = dir_q;
        tc_d   = tc_q;
        if (press_any && !is_opposite(press_dir, ref_dir)) begin
            pend_d = press_dir;
        end
        if (tick_c) begin
            dir_d = pend_q;
            tc_d  = tc_q + TICK_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            period_q <= PW'(BASE_PERIOD);
            dir_q    <= DIR_RIGHT;
            pend_q   <= DIR_RIGHT;
            tc_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            tc_q     <= tc_d;
        end
    end

    assign tick        = tick_c;
    assign clear_pulse = clear_c;
    assign dir         = dir_q;
    assign tick_count  = tc_q;

endmodule

// File: tb/tb_game_tick_input.sv
// Bench for game_tick_input with a short period, short clear lead and fast
// debounce so that every timing corner fits in a few hundred cycles.
module tb_game_tick_input;

    localparam int BASE_PERIOD = 16;
    localparam int CLEAR_LEAD  = 4;
    localparam int N_BTN       = 5;
    localparam int DB_CYCLES   = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_BTN-1:0] btn_n;
    logic [1:0]       speed;
    logic             pause;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [1:0]       dir;
    logic             clear_pulse;
    logic             tick;
    logic [15:0]      tick_count;

    game_tick_input #(
        .BASE_PERIOD(BASE_PERIOD),
        .CLEAR_LEAD (CLEAR_LEAD),
        .N_BTN      (N_BTN),
        .DB_CYCLES  (DB_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_n      (btn_n),
        .speed      (speed),
        .pause      (pause),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .dir        (dir),
        .clear_pulse(clear_pulse),
        .tick       (tick),
        .tick_count (tick_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [1:0] exp_q[$];

    typedef struct {
        int          cyc;
        logic        t;
        logic        c;
        logic [15:0] n;
    } fr_vec_t;

    fr_vec_t fr_tab[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        btn_n = '1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " level"}, btn_level, '0);
        chk({tag, " press"}, btn_press, '0);
        chk({tag, " tick"}, tick, 0);
        chk({tag, " clear"}, clear_pulse, 0);
        chk({tag, " count"}, tick_count, 0);
        chk({tag, " dir"}, dir, 0);
    endtask

    // Waits (bounded) for the next tick and compares the committed direction
    // in the following cycle against the oldest expected entry.
    task automatic wait_tick_dir(input string name);
        int n;
        logic [1:0] e;
        n = 0;
        while (tick !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        if (tick !== 1'b1) begin
            chk({name, " tick timeout"}, 0, 1);
        end else begin
            step();
            if (exp_q.size() == 0) begin
                chk({name, " queue empty"}, 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk(name, dir, e);
            end
        end
    endtask

    initial begin
        int nticks;
        reset = 1'b1;
        btn_n = '1;
        speed = 2'd0;
        pause = 1'b0;

        fr_tab[0] = '{0,  1'b0, 1'b0, 16'd0};
        fr_tab[1] = '{11, 1'b0, 1'b1, 16'd0};
        fr_tab[2] = '{12, 1'b0, 1'b0, 16'd0};
        fr_tab[3] = '{15, 1'b1, 1'b0, 16'd0};
        fr_tab[4] = '{16, 1'b0, 1'b0, 16'd1};
        fr_tab[5] = '{27, 1'b0, 1'b1, 16'd1};
        fr_tab[6] = '{31, 1'b1, 1'b0, 16'd1};
        fr_tab[7] = '{32, 1'b0, 1'b0, 16'd2};
        fr_tab[8] = '{47, 1'b1, 1'b0, 16'd2};
        fr_tab[9] = '{48, 1'b0, 1'b0, 16'd3};

        // Free run at speed 0.
        do_reset();
        check_reset_state("reset");
        nticks = 0;
        for (int c = 0; c <= 48; c++) begin
            if (c > 0) step();
            if (tick === 1'b1) nticks++;
            for (int k = 0; k < 10; k++) begin
                if (fr_tab[k].cyc == c) begin
                    chk("freerun tick", tick, fr_tab[k].t);
                    chk("freerun clear", clear_pulse, fr_tab[k].c);
                    chk("freerun count", tick_count, fr_tab[k].n);
                end
            end
        end
        chk("freerun tick total", nticks, 3);

        // Speed change mid-period: 16-cycle period completes, then period 4.
        do_reset();
        run_to(5);
        speed = 2'd2;
        for (int c = 5; c <= 32; c++) begin
            run_to(c);
            chk("speed2 tick", tick, (c == 15) || (c > 15 && ((c - 15) % 4) == 0));
        end
        speed = 2'd0;

        // Two-cycle glitch then a real press on down.
        do_reset();
        btn_n[1] = 1'b0;
        run_to(2);
        btn_n[1] = 1'b1;
        run_to(6);
        btn_n[1] = 1'b0;
        for (int c = 2; c <= 14; c++) begin
            run_to(c);
            chk("glitch press", btn_press[1], c == 11);
            chk("glitch level", btn_level[1], c >= 11);
        end
        exp_q.push_back(2'b01);
        btn_n[1] = 1'b1;
        wait_tick_dir("down dir");

        // Left ignored against right; down and up together, down wins.
        do_reset();
        btn_n[1] = 1'b0;
        btn_n[2] = 1'b0;
        exp_q.push_back(2'b01);
        run_to(5);
        chk("dual press down", btn_press[1], 1);
        chk("dual press up", btn_press[2], 1);
        run_to(6);
        btn_n[1] = 1'b1;
        btn_n[2] = 1'b1;
        btn_n[3] = 1'b0;
        run_to(11);
        chk("left press", btn_press[3], 1);
        run_to(12);
        btn_n[3] = 1'b1;
        wait_tick_dir("left ignored dir");

        // Press landing in a tick cycle commits one tick later.
        do_reset();
        btn_n[1] = 1'b0;
        exp_q.push_back(2'b01);
        run_to(6);
        btn_n[1] = 1'b1;
        run_to(10);
        btn_n[3] = 1'b0;
        run_to(15);
        chk("tick-cycle press", btn_press[3], 1);
        chk("tick-cycle tick", tick, 1);
        exp_q.push_back(2'b11);
        wait_tick_dir("old pending commit");
        btn_n[3] = 1'b1;
        run_to(18);
        btn_n[4] = 1'b0;
        run_to(23);
        chk("generic press", btn_press[4], 1);
        chk("generic level", btn_level[4], 1);
        run_to(24);
        btn_n[4] = 1'b1;
        wait_tick_dir("new pending commit");

        // Pause for 20 cycles, then reset mid-period.
        do_reset();
        run_to(5);
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("pause tick", tick, 0);
            chk("pause clear", clear_pulse, 0);
            chk("pause count", tick_count, 0);
            step();
        end
        pause = 1'b0;
        for (int c = 25; c <= 35; c++) begin
            run_to(c);
            chk("resume tick", tick, c == 35);
            chk("resume clear", clear_pulse, c == 31);
        end
        run_to(36);
        chk("resume count", tick_count, 1);
        run_to(40);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        check_reset_state("midreset");
        for (int c = 0; c <= 15; c++) begin
            run_to(c);
            chk("post-reset tick", tick, c == 15);
        end
        reset = 1'b1;
        #1;
        chk("reset suppresses tick", tick, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        chk("suppressed count", tick_count, 0);
        chk("suppressed dir", dir, 0);

        chk("queue drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
